// File: rtl/decode_inst_queue_pkg.sv
// rtl/decode_inst_queue_pkg.sv - shared decode widths, unit codes and instruction bundle layout
package decode_inst_queue_pkg;

    localparam int addressWidth            = 64;
    localparam int opcodeSize              = 12;
    localparam int funcUnitCodeSize        = 3;
    localparam int instructionCounterWidth = 64;
    localparam int instMinIdWidth          = 7;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int regAccessPatternSize    = 2;
    localparam int bodyWidth               = 84;

    typedef enum logic [funcUnitCodeSize-1:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_FPU = 3'd2,
        FU_LSU = 3'd3,
        FU_BRU = 3'd4,
        FU_SYS = 3'd5
    } func_unit_e;

    // Packing order shared with the decode mux; field order is the bit layout.
    typedef struct packed {
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            address;
        logic [funcUnitCodeSize-1:0]        func_unit;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [instMinIdWidth-1:0]          min_id;
        logic                               is64;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic [regAccessPatternSize-1:0]    op3rw;
        logic [regAccessPatternSize-1:0]    op4rw;
        logic                               op1_is_reg;
        logic                               op2_is_reg;
        logic                               op3_is_reg;
        logic                               op4_is_reg;
        logic [bodyWidth-1:0]               body;
    } decoded_inst_t;

    localparam int ENTRY_WIDTH = $bits(decoded_inst_t);

endpackage

// File: rtl/decode_inst_queue_if.sv
// rtl/decode_inst_queue_if.sv - decode-mux push bundle and dispatch head bundle
interface decode_inst_queue_if
    import decode_inst_queue_pkg::*;
#(
    parameter int queueDepth = 8
);
    localparam int CW = $clog2(queueDepth) + 1;

    logic                               enable_i;
    logic [opcodeSize-1:0]              opcode_i;
    logic [addressWidth-1:0]            address_i;
    logic [funcUnitCodeSize-1:0]        funcUnitType_i;
    logic [instructionCounterWidth-1:0] majID_i;
    logic [instMinIdWidth-1:0]          minID_i;
    logic                               is64Bit_i;
    logic [PidSize-1:0]                 pid_i;
    logic [TidSize-1:0]                 tid_i;
    logic [regAccessPatternSize-1:0]    op1rw_i, op2rw_i, op3rw_i, op4rw_i;
    logic                               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
    logic [bodyWidth-1:0]               body_i;
    logic                               flush_i;
    logic                               stall_o;

    logic                               valid_o;
    logic                               ready_i;
    logic [opcodeSize-1:0]              opcode_o;
    logic [addressWidth-1:0]            address_o;
    logic [funcUnitCodeSize-1:0]        funcUnitType_o;
    logic [instructionCounterWidth-1:0] majID_o;
    logic [instMinIdWidth-1:0]          minID_o;
    logic                               is64Bit_o;
    logic [PidSize-1:0]                 pid_o;
    logic [TidSize-1:0]                 tid_o;
    logic [regAccessPatternSize-1:0]    op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic                               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
    logic [bodyWidth-1:0]               body_o;
    logic [CW-1:0]                      count_o;
    logic                               overflow_o;

    modport master (
        output enable_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
               pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i, flush_i, ready_i,
        input  stall_o, valid_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
               is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o, count_o, overflow_o
    );

    modport slave (
        input  enable_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
               pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i, flush_i, ready_i,
        output stall_o, valid_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
               is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o, count_o, overflow_o
    );

endinterface

// File: rtl/decode_inst_queue_sync_fifo_ctrl.sv
// rtl/decode_inst_queue_sync_fifo_ctrl.sv - wrap-bit pointer, occupancy and push/pop accept logic
module sync_fifo_ctrl #(
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req,
    input  logic          ready,
    input  logic          flush,
    output logic [IW-1:0] wr_idx,
    output logic [IW-1:0] rd_idx,
    output logic [IW:0]   count,
    output logic [IW:0]   count_next,
    output logic          empty,
    output logic          full,
    output logic          push,
    output logic          pop,
    output logic          overflow
);

    logic [IW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic        pop_raw;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign pop_raw = !empty && ready;

    // A pop in the same cycle frees the slot a full-queue push needs; flush cancels both.
    assign pop  = pop_raw && !flush;
    assign push = push_req && (!full || pop_raw) && !flush;

    assign wr_nxt     = wr_ptr + {{IW{1'b0}}, push};
    assign rd_nxt     = flush ? wr_ptr : rd_ptr + {{IW{1'b0}}, pop};
    assign count      = wr_ptr - rd_ptr;
    assign count_next = wr_nxt - rd_nxt;
    assign wr_idx     = wr_ptr[IW-1:0];
    assign rd_idx     = rd_ptr[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (push_req && full && !pop_raw && !flush)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/decode_inst_queue.sv
// rtl/decode_inst_queue.sv - FWFT queue of decoded instructions with early stall, flush and overflow flag
module decode_inst_queue
    import decode_inst_queue_pkg::*;
#(
    parameter int queueDepth    = 8,
    parameter int stallHeadroom = 2
) (
    input logic                    clock_i,
    input logic                    reset_i,
    decode_inst_queue_if.slave     bus
);

    localparam int IW = $clog2(queueDepth);
    localparam logic [IW:0] STALL_AT = (IW+1)'(queueDepth - stallHeadroom);

    decoded_inst_t mem [queueDepth];
    decoded_inst_t in_entry, head;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [IW:0]   count, count_next;
    logic          empty, full, push, pop, overflow, stall;

    sync_fifo_ctrl #(.DEPTH(queueDepth)) u_ctrl (
        .clk        (clock_i),
        .rst        (reset_i),
        .push_req   (bus.enable_i),
        .ready      (bus.ready_i),
        .flush      (bus.flush_i),
        .wr_idx     (wr_idx),
        .rd_idx     (rd_idx),
        .count      (count),
        .count_next (count_next),
        .empty      (empty),
        .full       (full),
        .push       (push),
        .pop        (pop),
        .overflow   (overflow)
    );

    always_comb begin
        in_entry            = '0;
        in_entry.opcode     = bus.opcode_i;
        in_entry.address    = bus.address_i;
        in_entry.func_unit  = bus.funcUnitType_i;
        in_entry.maj_id     = bus.majID_i;
        in_entry.min_id     = bus.minID_i;
        in_entry.is64       = bus.is64Bit_i;
        in_entry.pid        = bus.pid_i;
        in_entry.tid        = bus.tid_i;
        in_entry.op1rw      = bus.op1rw_i;
        in_entry.op2rw      = bus.op2rw_i;
        in_entry.op3rw      = bus.op3rw_i;
        in_entry.op4rw      = bus.op4rw_i;
        in_entry.op1_is_reg = bus.op1IsReg_i;
        in_entry.op2_is_reg = bus.op2IsReg_i;
        in_entry.op3_is_reg = bus.op3IsReg_i;
        in_entry.op4_is_reg = bus.op4IsReg_i;
        in_entry.body       = bus.body_i;
    end

    // Storage is cleared on reset so idle head fields never show X.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < queueDepth; i++)
                mem[i] <= '0;
            stall <= 1'b0;
        end else begin
            if (push)
                mem[wr_idx] <= in_entry;
            stall <= (count_next >= STALL_AT);
        end
    end

    assign head = mem[rd_idx];

    assign bus.valid_o        = !empty;
    assign bus.stall_o        = stall;
    assign bus.count_o        = count;
    assign bus.overflow_o     = overflow;
    assign bus.opcode_o       = head.opcode;
    assign bus.address_o      = head.address;
    assign bus.funcUnitType_o = head.func_unit;
    assign bus.majID_o        = head.maj_id;
    assign bus.minID_o        = head.min_id;
    assign bus.is64Bit_o      = head.is64;
    assign bus.pid_o          = head.pid;
    assign bus.tid_o          = head.tid;
    assign bus.op1rw_o        = head.op1rw;
    assign bus.op2rw_o        = head.op2rw;
    assign bus.op3rw_o        = head.op3rw;
    assign bus.op4rw_o        = head.op4rw;
    assign bus.op1IsReg_o     = head.op1_is_reg;
    assign bus.op2IsReg_o     = head.op2_is_reg;
    assign bus.op3IsReg_o     = head.op3_is_reg;
    assign bus.op4IsReg_o     = head.op4_is_reg;
    assign bus.body_o         = head.body;

endmodule

// File: tb/tb_decode_inst_queue.sv
// tb/tb_decode_inst_queue.sv - vector table plus queue-model random checks for decode_inst_queue
module tb_decode_inst_queue;
    import decode_inst_queue_pkg::*;

    localparam int DEPTH    = 8;
    localparam int HEADROOM = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_inst_queue_if #(.queueDepth(DEPTH)) bus ();

    decode_inst_queue #(.queueDepth(DEPTH), .stallHeadroom(HEADROOM)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        rst, en, rdy, fl;
        logic [63:0] maj;
        logic        ev;
        logic [3:0]  ec;
        logic        es, eo;
        logic [63:0] eh;
    } vec_t;

    vec_t          tbl[$];
    decoded_inst_t mq[$];
    logic          m_ovf;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int r, input int e, input int rd, input int f, input int maj,
                       input int ev, input int ec, input int es, input int eo, input int eh);
        vec_t v;
        v.rst = r[0]; v.en = e[0]; v.rdy = rd[0]; v.fl = f[0];
        v.maj = 64'(maj); v.ev = ev[0]; v.ec = 4'(ec); v.es = es[0]; v.eo = eo[0];
        v.eh = 64'(eh);
        tbl.push_back(v);
    endtask

    task automatic set_in(input decoded_inst_t d);
        bus.opcode_i       = d.opcode;
        bus.address_i      = d.address;
        bus.funcUnitType_i = d.func_unit;
        bus.majID_i        = d.maj_id;
        bus.minID_i        = d.min_id;
        bus.is64Bit_i      = d.is64;
        bus.pid_i          = d.pid;
        bus.tid_i          = d.tid;
        bus.op1rw_i        = d.op1rw;
        bus.op2rw_i        = d.op2rw;
        bus.op3rw_i        = d.op3rw;
        bus.op4rw_i        = d.op4rw;
        bus.op1IsReg_i     = d.op1_is_reg;
        bus.op2IsReg_i     = d.op2_is_reg;
        bus.op3IsReg_i     = d.op3_is_reg;
        bus.op4IsReg_i     = d.op4_is_reg;
        bus.body_i         = d.body;
    endtask

    function automatic decoded_inst_t get_head();
        decoded_inst_t h;
        h.opcode = bus.opcode_o;     h.address = bus.address_o;
        h.func_unit = bus.funcUnitType_o; h.maj_id = bus.majID_o;
        h.min_id = bus.minID_o;      h.is64 = bus.is64Bit_o;
        h.pid = bus.pid_o;           h.tid = bus.tid_o;
        h.op1rw = bus.op1rw_o;       h.op2rw = bus.op2rw_o;
        h.op3rw = bus.op3rw_o;       h.op4rw = bus.op4rw_o;
        h.op1_is_reg = bus.op1IsReg_o; h.op2_is_reg = bus.op2IsReg_o;
        h.op3_is_reg = bus.op3IsReg_o; h.op4_is_reg = bus.op4IsReg_o;
        h.body = bus.body_o;
        return h;
    endfunction

    function automatic decoded_inst_t rand_inst();
        decoded_inst_t d;
        d.opcode = 12'($urandom);    d.address = {$urandom, $urandom};
        d.func_unit = 3'($urandom);  d.maj_id = {$urandom, $urandom};
        d.min_id = 7'($urandom);     d.is64 = 1'($urandom);
        d.pid = 20'($urandom);       d.tid = 16'($urandom);
        d.op1rw = 2'($urandom);      d.op2rw = 2'($urandom);
        d.op3rw = 2'($urandom);      d.op4rw = 2'($urandom);
        d.op1_is_reg = 1'($urandom); d.op2_is_reg = 1'($urandom);
        d.op3_is_reg = 1'($urandom); d.op4_is_reg = 1'($urandom);
        d.body = {20'($urandom), $urandom, $urandom};
        return d;
    endfunction

    // Model: a plain queue of instructions; the head is the oldest accepted one.
    task automatic mcycle(input logic r, input logic en, input logic rdy, input logic fl);
        decoded_inst_t d;
        decoded_inst_t got;
        logic          do_pop, is_full;
        d = rand_inst();
        set_in(d);
        rst = r; bus.enable_i = en; bus.ready_i = rdy; bus.flush_i = fl;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            is_full = (mq.size() == DEPTH);
            if (en && is_full && !do_pop) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (en && (!is_full || do_pop)) mq.push_back(d);
        end
        @(posedge clk); #1;
        chk("m_valid", bus.valid_o, mq.size() > 0);
        chk("m_count", bus.count_o, mq.size());
        chk("m_stall", bus.stall_o, mq.size() >= DEPTH - HEADROOM);
        chk("m_overflow", bus.overflow_o, m_ovf);
        if (mq.size() > 0) begin
            got = get_head();
            if (got != mq[0]) begin
                checks++; errors++;
                $display("FAIL m_head: got maj %0h opc %0h expected maj %0h opc %0h",
                         got.maj_id, got.opcode, mq[0].maj_id, mq[0].opcode);
            end else begin
                checks++;
            end
        end
    endtask

    initial begin
        decoded_inst_t d;
        rst = 1'b1;
        bus.enable_i = 1'b0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
        set_in('0);
        m_ovf = 1'b0;

        add(1,0,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,1, 1,1,0,0,1);
        add(0,0,1,0,0, 0,0,0,0,0);
        for (int m = 1; m <= 8; m++) add(0,1,0,0,m, 1,m,(m >= 6),0,1);
        add(0,1,0,0,9, 1,8,1,1,1);
        for (int k = 1; k <= 8; k++) add(0,0,1,0,0, (k < 8),8-k,((8-k) >= 6),1,k+1);
        for (int m = 10; m <= 14; m++) add(0,1,0,0,m, 1,m-9,0,1,10);
        add(0,1,1,1,15, 0,0,0,1,0);
        add(0,1,0,0,16, 1,1,0,1,16);
        add(0,0,1,0,0, 0,0,0,1,0);
        add(1,0,0,0,0, 0,0,0,0,0);
        for (int m = 1; m <= 8; m++) add(0,1,0,0,m, 1,m,(m >= 6),0,1);
        add(0,1,1,0,9, 1,8,1,0,2);
        for (int k = 1; k <= 8; k++) add(0,0,1,0,0, (k < 8),8-k,((8-k) >= 6),0,k+2);
        for (int m = 1; m <= 4; m++) add(0,1,0,0,m, 1,m,0,0,1);
        add(1,1,0,0,5, 0,0,0,0,0);

        foreach (tbl[i]) begin
            d = '0;
            d.maj_id = tbl[i].maj;
            d.opcode = 12'h0A4 + tbl[i].maj[11:0];
            d.body   = 84'(tbl[i].maj);
            set_in(d);
            rst = tbl[i].rst; bus.enable_i = tbl[i].en;
            bus.ready_i = tbl[i].rdy; bus.flush_i = tbl[i].fl;
            @(posedge clk); #1;
            chk($sformatf("row%0d_valid", i), bus.valid_o, tbl[i].ev);
            chk($sformatf("row%0d_count", i), bus.count_o, tbl[i].ec);
            chk($sformatf("row%0d_stall", i), bus.stall_o, tbl[i].es);
            chk($sformatf("row%0d_overflow", i), bus.overflow_o, tbl[i].eo);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_head_maj", i), bus.majID_o, tbl[i].eh);
                chk($sformatf("row%0d_head_opc", i), bus.opcode_o, 12'h0A4 + tbl[i].eh[11:0]);
            end
        end

        chk("reset_head_opcode", bus.opcode_o, 0);
        chk("reset_head_maj", bus.majID_o, 0);
        chk("reset_head_addr", bus.address_o, 0);
        chk("reset_head_body_zero", bus.body_o == '0, 1);

        mcycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            mcycle(0, 1, (i % 2) == 0, 0);
            chk("stream_count_bound", bus.count_o <= DEPTH, 1);
        end
        for (int i = 0; i < 12; i++) mcycle(0, 0, 1, 0);

        for (int i = 0; i < 600; i++)
            mcycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31) == 0);
        mcycle(1, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            mcycle(0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 63) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Receiving end of the decode-mux output bundle.
- Captures one decoded instruction per cycle into a FIFO of fixed-width entries.
- Presents the oldest entry to dispatch using a valid/ready handshake.
- The upstream mux has no ready input, so this block produces an early stall_o with headroom, a flush path for redirects, and a sticky overflow flag for protocol violations.

Parameters:
- addressWidth, 64, instruction address width
- opcodeSize, 12, decoded opcode width
- funcUnitCodeSize, 3, functional-unit/format code width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- regAccessPatternSize, 2, per-operand rw flags ([0] read, [1] write)
- bodyWidth, 84, operand body width (4 regs + 64b imm)
- queueDepth, 8, entries; power of two, >= 4
- stallHeadroom, 2, free slots reserved for in-flight upstream instructions

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- enable_i  in  1  push strobe from decode mux
- opcode_i  in  12  opcode
- address_i  in  64  instruction address
- funcUnitType_i  in  3  unit/format code
- majID_i  in  64  major ID
- minID_i  in  7  minor ID
- is64Bit_i  in  1  64b mode
- pid_i  in  20  process ID
- tid_i  in  16  thread ID
- op1rw_i..op4rw_i  in  2 each  operand access pattern
- op1IsReg_i..op4IsReg_i  in  1 each  operand-is-register flags
- body_i  in  84  operand body
- flush_i  in  1  discard all queued entries
- stall_o  out  1  upstream must stop issuing new instructions
- valid_o  out  1  head entry valid
- ready_i  in  1  dispatch accepts head
- (opcode_o … body_o)  out  same widths as the matching inputs  head-entry fields
- count_o  out  log2(queueDepth)+1  occupancy
- overflow_o  out  1  sticky: a push was dropped while full

Behaviour:
- Entry = concatenation of all 11 input field groups, 283 bits at default parameters. The queue stores it unmodified.
- Pointers: wrPtr and rdPtr are log2(queueDepth)+1 bits. The MSB is the wrap bit.
  - empty = (wrPtr == rdPtr)
  - full = index bits equal and wrap bits differ
  - count_o = wrPtr - rdPtr, modulo 2^(log2(depth)+1)
- Output side is first-word-fall-through:
  - valid_o = !empty.
  - Head fields are driven combinationally from storage[rdPtr index].
  - When valid_o = 0 the head fields are don't-care, but they must not be X after reset; storage is zeroed on reset.
- pop = valid_o & ready_i, evaluated at the clock edge. rdPtr increments by 1.
- push = enable_i & (!full | pop). The entry is written at wrPtr and wrPtr increments. Push and pop in the same cycle leave count_o unchanged.
- Full with enable_i=1 and no pop: the entry is dropped, pointers hold, and overflow_o is set to 1. overflow_o holds until reset; flush does not clear it.
- Empty with enable_i=1 and ready_i=1: the entry is not forwarded in the same cycle. valid_o rises the next cycle (one-cycle latency from enable_i to valid_o).
- flush_i=1: rdPtr <= wrPtr, i.e. the queue is empty next cycle.
  - flush has priority: a same-cycle push and pop are both ignored.
  - overflow_o is unaffected.
- stall_o is registered: stall_o <= (next count >= queueDepth - stallHeadroom). It deasserts the cycle after occupancy drops below that threshold.
- Reset (synchronous, any cycle including mid-push): wrPtr = rdPtr = 0, valid_o = 0, count_o = 0, stall_o = 0, overflow_o = 0, storage zeroed. reset_i has priority over flush, push and pop.
- Wrap-around: the pointers roll over naturally. No special case beyond the full/empty equations.

Decomposition:
- Shared decode package/header holds:
  - field-width constants (opcode, ID, PID/TID, rw, body)
  - the funcUnit/format code constants
  - the decoded-instruction bundle typedef/width macro, so the mux and this queue agree on packing order
- One natural sub-module: sync_fifo_ctrl. It owns pointer/count/full/empty/push-accept logic, parameterised on depth.
- Storage and field pack/unpack stay in decode_inst_queue.

Test Plan:
- Reset, then push 1 entry (opcode=12'h0A5, majID=64'd1, body=84'h1) with ready_i=0 -> next cycle valid_o=1, opcode_o=0A5, count_o=1; assert ready_i -> valid_o=0 next cycle.
- Push 8 consecutive entries with majID 1..8 and ready_i=0 -> stall_o=1 from the cycle after count reaches 6; count_o=8; a 9th push sets overflow_o=1 and count stays 8; drain returns majIDs 1..8 in order.
- Full queue, push and pop in the same cycle with majID=9 -> count_o stays 8, pop returns 1, and 9 is last out; overflow_o stays 0.
- Stream 20 entries with ready_i toggling 1,0 -> in-order output with no loss or duplication across pointer wrap; count never exceeds 8.
- 5 entries queued, flush_i=1 together with enable_i=1 and ready_i=1 -> next cycle valid_o=0 and count_o=0, and the pushed entry is discarded; overflow_o keeps its prior value.
- Fill to 4, then reset_i=1 in the same cycle as a push -> count_o=0, valid_o=0, stall_o=0, overflow_o=0; head fields read 0.
